// File: rtl/comp_pkg.sv
// Shared definitions for the dictionary compressor and its decompress counterpart:
// token codes, token lengths and the encoder FSM state.
package comp_pkg;
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_FULL = 2'b01;
    localparam logic [1:0] CODE_PART = 2'b10;
    localparam logic [1:0] CODE_LIT  = 2'b11;

    localparam logic [7:0] LEN_ZERO = 8'd2;
    localparam logic [7:0] LEN_FULL = 8'd6;
    localparam logic [7:0] LEN_PART = 8'd14;
    localparam logic [7:0] LEN_LIT  = 8'd34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_FLUSH
    } state_t;
endpackage

// File: rtl/comp_dict_match.sv
// 16-entry FIFO dictionary with full/partial match search and lowest-index priority.
// Match result is combinational on current contents; the write lands on the next edge.
module comp_dict_match
    import comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WORD  = 16,
    parameter int IDX_W = $clog2(WORD)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_enc,
    output logic [1:0]       o_code,
    output logic [IDX_W-1:0] o_idx
);
    logic [WIDTH-1:0] dict_q [WORD];
    logic [IDX_W-1:0] wr_ptr_q;
    logic             full_hit, part_hit;
    logic [IDX_W-1:0] full_idx, part_idx;

    // Scan from the top down so the lowest matching slot is the one left standing.
    always_comb begin
        full_hit = 1'b0;
        part_hit = 1'b0;
        full_idx = '0;
        part_idx = '0;
        for (int i = WORD - 1; i >= 0; i--) begin
            if (dict_q[i] == i_word) begin
                full_hit = 1'b1;
                full_idx = IDX_W'(i);
            end
            if (dict_q[i][WIDTH-1:8] == i_word[WIDTH-1:8]) begin
                part_hit = 1'b1;
                part_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        o_code = CODE_LIT;
        o_idx  = '0;
        if (i_word == '0) begin
            o_code = CODE_ZERO;
        end else if (full_hit) begin
            o_code = CODE_FULL;
            o_idx  = full_idx;
        end else if (part_hit) begin
            o_code = CODE_PART;
            o_idx  = part_idx;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < WORD; i++) dict_q[i] <= '0;
            wr_ptr_q <= '0;
        end else if (i_enc && (o_code == CODE_PART || o_code == CODE_LIT)) begin
            dict_q[wr_ptr_q] <= i_word;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/compressor.sv
// Dictionary word compressor: packs variable-length tokens LSB-first into 128-bit chunks.
// Latency: first token enters the packer one cycle after accept; encoding stalls while a full chunk waits for i_ready.
module compressor
    import comp_pkg::*;
#(
    parameter int WIDTH_DATA_IN = 128,
    parameter int WIDTH         = 32,
    parameter int WORD          = 16,
    parameter int I_WORD        = 196,
    parameter int LENGTH_CODE   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH_DATA_IN-1:0] i_data,
    input  logic                     i_last,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH_DATA_IN-1:0] o_data,
    output logic [7:0]               o_bits,
    output logic                     o_last
);
    localparam int IDX_W = $clog2(WORD);
    localparam int TOK_W = WIDTH + LENGTH_CODE;
    localparam logic [7:0] CHUNK = 8'(WIDTH_DATA_IN);

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [WIDTH_DATA_IN-1:0] blk_q, blk_d;
    logic                     last_q, last_d;
    logic [I_WORD-1:0]        acc_q, acc_d;
    logic [7:0]               fill_q, fill_d, fill_base;
    logic                     valid_q, ready_q, olast_q;
    logic [7:0]               bits_q;

    logic [WIDTH-1:0]         word;
    logic [1:0]               code;
    logic [IDX_W-1:0]         idx;
    logic [TOK_W-1:0]         tok;
    logic [7:0]               tok_len;
    logic                     pop, enc;

    assign word = blk_q[32'(cnt_q) * WIDTH +: WIDTH];
    assign pop  = valid_q && i_ready;
    assign enc  = (state_q == ST_ENC) && (fill_q < CHUNK || pop);

    comp_dict_match #(.WIDTH(WIDTH), .WORD(WORD), .IDX_W(IDX_W)) u_dict (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_word  (word),
        .i_enc   (enc),
        .o_code  (code),
        .o_idx   (idx)
    );

    always_comb begin
        tok     = '0;
        tok_len = LEN_ZERO;
        case (code)
            CODE_FULL: begin
                tok     = TOK_W'({idx, CODE_FULL});
                tok_len = LEN_FULL;
            end
            CODE_PART: begin
                tok     = TOK_W'({word[7:0], idx, CODE_PART});
                tok_len = LEN_PART;
            end
            CODE_LIT: begin
                tok     = {word, CODE_LIT};
                tok_len = LEN_LIT;
            end
            default: ;
        endcase
    end

    // A pop and an insert in the same cycle: the token lands relative to the post-shift fill.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        last_d    = last_q;
        fill_base = fill_q;
        if (pop) fill_base = (fill_q >= CHUNK) ? fill_q - CHUNK : 8'd0;
        acc_d     = pop ? (acc_q >> WIDTH_DATA_IN) : acc_q;
        if (enc) acc_d = acc_d | (I_WORD'(tok) << fill_base);
        fill_d    = fill_base + (enc ? tok_len : 8'd0);
        case (state_q)
            ST_IDLE: if (i_valid && ready_q) begin
                blk_d   = i_data;
                last_d  = i_last;
                cnt_d   = '0;
                state_d = ST_ENC;
            end
            ST_ENC: if (enc) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 2'd3) state_d = last_q ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: if ((pop && fill_q <= CHUNK) || fill_q == 8'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            olast_q <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            valid_q <= (fill_d >= CHUNK) || (state_d == ST_FLUSH && fill_d != 8'd0);
            ready_q <= (state_d == ST_IDLE);
            olast_q <= (state_d == ST_FLUSH) && (fill_d != 8'd0) && (fill_d <= CHUNK);
            bits_q  <= (fill_d >= CHUNK) ? CHUNK : fill_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_last  = olast_q;
    assign o_bits  = bits_q;
    assign o_data  = acc_q[WIDTH_DATA_IN-1:0];
endmodule

// File: tb/tb_compressor.sv
// Bench for compressor: hand-computed single-block vectors plus a reference-model scoreboard
// for multi-block streams, backpressure stalls, dictionary wrap and reset mid-block.
module tb_compressor;
    logic         i_clk = 1'b0;
    logic         i_reset, i_valid, o_ready, i_last, o_valid, i_ready, o_last;
    logic [127:0] i_data, o_data;
    logic [7:0]   o_bits;

    always #5 i_clk = ~i_clk;

    compressor dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_bits  (o_bits),
        .o_last  (o_last)
    );

    typedef struct {
        logic [127:0] data;
        logic [7:0]   bits;
        logic         last;
    } chunk_t;

    typedef struct {
        logic [127:0] blk;
        logic [127:0] exp_data;
        logic [7:0]   exp_bits;
    } vec_t;

    chunk_t       exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  md [16];
    int           mptr;
    bit           mbits[$];
    logic         hold_vld;
    logic [127:0] hold_dat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: independent token encoder and bit-stream chunker.
    task automatic app(input logic [33:0] v, input int len);
        for (int i = 0; i < len; i++) mbits.push_back(v[i]);
    endtask

    task automatic model_word(input logic [31:0] w);
        int fi = -1;
        int pi = -1;
        for (int i = 0; i < 16; i++) begin
            if (fi < 0 && md[i] == w) fi = i;
            if (pi < 0 && md[i][31:8] == w[31:8]) pi = i;
        end
        if (w == 32'h0) begin
            app(34'h0, 2);
        end else if (fi >= 0) begin
            app({28'b0, fi[3:0], 2'b01}, 6);
        end else begin
            if (pi >= 0) app({20'b0, w[7:0], pi[3:0], 2'b10}, 14);
            else         app({w, 2'b11}, 34);
            md[mptr] = w;
            mptr = (mptr + 1) % 16;
        end
    endtask

    task automatic model_block(input logic [127:0] b, input bit last);
        logic [127:0] d;
        int n;
        for (int k = 0; k < 4; k++) model_word(b[k*32 +: 32]);
        while (mbits.size() > 128 || (!last && mbits.size() == 128)) begin
            d = '0;
            for (int i = 0; i < 128; i++) d[i] = mbits.pop_front();
            exp_q.push_back('{d, 8'd128, 1'b0});
        end
        if (last && mbits.size() > 0) begin
            n = mbits.size();
            d = '0;
            for (int i = 0; i < n; i++) d[i] = mbits.pop_front();
            exp_q.push_back('{d, 8'(n), 1'b1});
        end
    endtask

    function automatic logic [31:0] lw(input int i, input logic [23:0] base);
        return {8'(i + 1), base};
    endfunction

    // Scoreboard consumer and hold-stability watch, sampled away from the rising edge.
    always @(negedge i_clk) begin
        chunk_t c;
        if (!i_reset) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chunk: got data %h bits %0d last %0d, none expected", o_data, o_bits, o_last);
                end else begin
                    c = exp_q.pop_front();
                    check("chunk_data", o_data, c.data);
                    check("chunk_bits", 128'(o_bits), 128'(c.bits));
                    check("chunk_last", 128'(o_last), 128'(c.last));
                end
            end
            if (o_valid && !i_ready) begin
                if (hold_vld) check("stall_data_stable", o_data, hold_dat);
                hold_vld = 1'b1;
                hold_dat = o_data;
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        hold_vld = 1'b0;
        repeat (3) @(posedge i_clk);
        for (int i = 0; i < 16; i++) md[i] = '0;
        mptr = 0;
        mbits.delete();
        exp_q.delete();
        #1 i_reset = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b, input bit last, input bit use_model);
        int n = 0;
        if (use_model) model_block(b, last);
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_data  = b;
        i_last  = last;
        while (o_ready !== 1'b1 && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: o_ready %b after %0d cycles, want 1", o_ready, n);
        end
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || o_valid) begin
            errors++;
            $display("FAIL %s_drain: %0d chunks outstanding, o_valid %b, want 0 and 0", name, exp_q.size(), o_valid);
        end
    endtask

    initial begin
        vec_t vt[4];
        vt[0] = '{128'h0, 128'h0, 8'd8};
        vt[1] = '{{4{32'hDEADBEEF}},
                  {76'b0, 6'b000001, 6'b000001, 6'b000001, 32'hDEADBEEF, 2'b11}, 8'd52};
        vt[2] = '{{4{32'hDEADBE12}},
                  {96'b0, 6'b000101, 6'b000101, 6'b000101, 8'h12, 4'h0, 2'b10}, 8'd32};
        vt[3] = '{{32'hDEADBE12, 32'h12345678, 32'hDEADBEEF, 32'h0},
                  {80'b0, 6'b000101, 32'h12345678, 2'b11, 6'b000001, 2'b00}, 8'd48};

        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        do_reset();

        check("reset_o_valid", 128'(o_valid), 128'd0);
        check("reset_o_data", o_data, 128'd0);
        check("reset_o_bits", 128'(o_bits), 128'd0);
        check("reset_o_last", 128'(o_last), 128'd0);
        @(posedge i_clk);
        #1 check("ready_after_reset", 128'(o_ready), 128'd1);

        // Single-block streams, each building on the dictionary left by the previous one.
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back('{vt[v].exp_data, vt[v].exp_bits, 1'b1});
            send_block(vt[v].blk, 1'b1, 1'b0);
            drain($sformatf("vec%0d", v));
        end

        // Sixteen distinct literals: 544 bits across four full chunks and a 32-bit tail.
        do_reset();
        for (int b = 0; b < 4; b++)
            send_block({lw(4*b+3, 24'hC0FFEE), lw(4*b+2, 24'hC0FFEE),
                        lw(4*b+1, 24'hC0FFEE), lw(4*b, 24'hC0FFEE)}, b == 3, 1'b1);
        drain("literals16");

        // Seventeenth literal wraps into slot 0; the first word then no longer matches.
        do_reset();
        for (int b = 0; b < 4; b++)
            send_block({lw(4*b+3, 24'hC0FFEE), lw(4*b+2, 24'hC0FFEE),
                        lw(4*b+1, 24'hC0FFEE), lw(4*b, 24'hC0FFEE)}, 1'b0, 1'b1);
        send_block({lw(2, 24'hC0FFEE), lw(0, 24'hC0FFEE), lw(0, 24'hC0FFEE), lw(16, 24'hC0FFEE)}, 1'b1, 1'b1);
        drain("wrap");

        // Backpressure: the second block stalls with a full chunk pending.
        do_reset();
        i_ready = 1'b0;
        send_block({lw(3, 24'h5A5A5A), lw(2, 24'h5A5A5A), lw(1, 24'h5A5A5A), lw(0, 24'h5A5A5A)}, 1'b0, 1'b1);
        send_block({lw(7, 24'h5A5A5A), lw(6, 24'h5A5A5A), lw(5, 24'h5A5A5A), lw(4, 24'h5A5A5A)}, 1'b0, 1'b1);
        repeat (20) @(negedge i_clk);
        check("stall_o_valid", 128'(o_valid), 128'd1);
        check("stall_o_ready", 128'(o_ready), 128'd0);
        i_ready = 1'b1;
        send_block({32'h0, lw(4, 24'h5A5A5A), 32'h0, lw(9, 24'h5A5A5A)}, 1'b1, 1'b1);
        drain("stall");

        // Reset shortly after accept: nothing from the aborted block may surface.
        send_block({4{lw(20, 24'h0F0F0F)}}, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check("post_reset_idle", 128'(o_valid), 128'd0);
        end
        exp_q.push_back('{128'h0, 8'd8, 1'b1});
        send_block(128'h0, 1'b1, 1'b0);
        drain("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
